// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported 256x16 data memory between the processor controller
// (CPU port) and an external host/debug loader (HOST port). Accesses are
// serialised by a three-state FSM (IDLE -> ACCESS -> DONE), so one access
// completes every three cycles. The CPU has fixed priority. A wait counter
// forces a host grant after MAX_WAIT consecutive lost arbitrations.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  -> CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata     <- one-cycle completion pulse, read data during ack
//   cpu_stall              <- cpu_req & ~cpu_ack (holds the controller)
//   host_*                 : same meaning as the CPU port
//   mem_rd/mem_wr/mem_addr/mem_wdata -> memory strobes, driven only in ACCESS
//   mem_rdata              <- registered memory read data (valid in DONE)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_SAT   = 4'd15;

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [3:0]  wait_cnt_r;

  // Fields latched from the winner on the IDLE->ACCESS edge
  logic        sel_r;      // 0 = CPU, 1 = HOST
  logic        we_r;
  logic [7:0]  addr_r;
  logic [15:0] wdata_r;

  logic        host_win_s;
  logic        cpu_win_s;
  logic        grant_s;
  logic        win_we_s;
  logic [7:0]  win_addr_s;
  logic [15:0] win_wdata_s;

  // Arbitration: only evaluated in IDLE; the host wins when the CPU is quiet
  // or when it has already lost MAX_WAIT times in a row.
  always_comb begin
    host_win_s = 1'b0;
    cpu_win_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      if (host_req && (!cpu_req || (wait_cnt_r >= WAIT_LIMIT))) begin
        host_win_s = 1'b1;
      end else if (cpu_req) begin
        cpu_win_s = 1'b1;
      end else begin
        host_win_s = 1'b0;
        cpu_win_s  = 1'b0;
      end
    end else begin
      host_win_s = 1'b0;
      cpu_win_s  = 1'b0;
    end
  end

  assign grant_s = host_win_s | cpu_win_s;

  // Winner's request fields, selected for latching and for the strobe outputs
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = 8'h00;
    win_wdata_s = 16'h0000;
    if (host_win_s) begin
      win_we_s    = host_we;
      win_addr_s  = host_addr;
      win_wdata_s = host_wdata;
    end else begin
      win_we_s    = cpu_we;
      win_addr_s  = cpu_addr;
      win_wdata_s = cpu_wdata;
    end
  end

  // Next-state logic: IDLE waits for a grant, ACCESS and DONE last one cycle
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, starvation counter and latched request fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      sel_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 8'h00;
      wdata_r    <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        sel_r   <= host_win_s;
        we_r    <= win_we_s;
        addr_r  <= win_addr_s;
        wdata_r <= win_wdata_s;
        // Counter only counts host losses; a host grant restarts it
        if (host_win_s) begin
          wait_cnt_r <= 4'd0;
        end else if (host_req && (wait_cnt_r != WAIT_SAT)) begin
          wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Registered memory strobes and acks. Strobes are loaded on the grant edge
  // so they are high exactly during ACCESS; acks are loaded on the
  // ACCESS->DONE edge so they pulse exactly during DONE. The async reset
  // clears them immediately, abandoning any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 16'h0000;
      cpu_ack   <= 1'b0;
      host_ack  <= 1'b0;
    end else begin
      if (grant_s) begin
        mem_rd    <= ~win_we_s;
        mem_wr    <= win_we_s;
        mem_addr  <= win_addr_s;
        mem_wdata <= win_wdata_s;
      end else begin
        mem_rd    <= 1'b0;
        mem_wr    <= 1'b0;
        mem_addr  <= 8'h00;
        mem_wdata <= 16'h0000;
      end
      cpu_ack  <= (state_r == ST_ACCESS) && !sel_r;
      host_ack <= (state_r == ST_ACCESS) && sel_r;
    end
  end

  // Read data arrives from the memory's output register during DONE, so it
  // is gated straight through rather than registered a second time.
  assign cpu_rdata  = (cpu_ack && !we_r)  ? mem_rdata : 16'h0000;
  assign host_rdata = (host_ack && !we_r) ? mem_rdata : 16'h0000;

  assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench for dmem_arbiter. Two random requester agents drive the
// CPU and HOST ports, a behavioural 256x16 memory answers the strobes, and a
// transaction-level model predicts every grant (who, what, which cycle) from
// the arbitration rules, pushing expected strobes and acks into queues. A
// separate monitor pops and compares whenever the DUT presents a strobe or
// an ack, and checks quiet outputs otherwise. Random reset pulses exercise
// abandoned accesses; a directed run after reset checks the starvation order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int ADDR_SPAN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_ack;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 48879);
  endfunction

  // Behavioural memory: write at the end of the strobe cycle, registered read
  logic [15:0] mem [256];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_rdata <= 16'h0000;
      mem_init  <= 1'b1;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int unsigned cyc;
  } strobe_t;

  typedef struct packed {
    logic        sel;
    logic [15:0] rdata;
    int unsigned cyc;
  } ack_t;

  strobe_t     sq[$];
  ack_t        aq[$];
  logic        ack_log[$];
  logic        log_en = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int          cpu_pct = 0;
  int          host_pct = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CPU requester: holds a request until acked, then maybe issues another
  logic c_seen;
  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    forever begin
      @(negedge clk); c_seen = cpu_ack;
      @(posedge clk); #1;
      if (!cpu_req || c_seen) begin
        if (int'($urandom_range(99)) < cpu_pct) begin
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(1));
          cpu_addr  = 8'($urandom_range(ADDR_SPAN - 1));
          cpu_wdata = 16'($urandom);
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
  end

  // HOST requester: same behaviour as the CPU agent
  logic h_seen;
  initial begin
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 16'h0000;
    forever begin
      @(negedge clk); h_seen = host_ack;
      @(posedge clk); #1;
      if (!host_req || h_seen) begin
        if (int'($urandom_range(99)) < host_pct) begin
          host_req   = 1'b1;
          host_we    = 1'($urandom_range(1));
          host_addr  = 8'($urandom_range(ADDR_SPAN - 1));
          host_wdata = 16'($urandom);
        end else begin
          host_req = 1'b0;
        end
      end
    end
  end

  // Reference model: one transaction per free slot, decided from the request
  // lines seen at the clock edge. Writes take effect only if reset is still
  // released at the edge that closes their strobe cycle.
  logic [15:0] ref_mem [256];
  int          losses = 0;
  int          busy = 0;
  logic        pend_wr = 1'b0;
  logic [7:0]  pend_addr;
  logic [15:0] pend_data;
  int unsigned pend_cyc;
  logic        m_host, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  strobe_t     m_s;
  ack_t        m_a;
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        sq.delete();
        aq.delete();
        losses  = 0;
        busy    = 0;
        pend_wr = 1'b0;
      end else begin
        if (pend_wr && pend_cyc == cyc) begin
          ref_mem[pend_addr] = pend_data;
          pend_wr = 1'b0;
        end
        if (busy > 0) begin
          busy--;
        end else if (cpu_req || host_req) begin
          m_host = host_req && (!cpu_req || losses >= MAX_WAIT);
          if (m_host) begin
            m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
            losses = 0;
          end else begin
            m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            if (host_req && losses < 15) losses++;
          end
          m_s.we = m_we; m_s.addr = m_addr; m_s.wdata = m_wdata; m_s.cyc = cyc;
          sq.push_back(m_s);
          m_a.sel = m_host; m_a.rdata = m_we ? 16'h0000 : ref_mem[m_addr]; m_a.cyc = cyc + 1;
          aq.push_back(m_a);
          if (m_we) begin
            pend_wr = 1'b1; pend_addr = m_addr; pend_data = m_wdata; pend_cyc = cyc + 1;
          end
          busy = 2;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard mid-cycle
  strobe_t o_s;
  ack_t    o_a;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset_quiet",
              {cpu_ack, host_ack, cpu_rdata, host_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_stall},
              {60'd0, cpu_req});
      end else begin
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
          check("strobe_missing", 64'(cyc), 64'(sq[0].cyc));
          void'(sq.pop_front());
        end
        while (aq.size() > 0 && aq[0].cyc < cyc) begin
          check("ack_missing", 64'(cyc), 64'(aq[0].cyc));
          void'(aq.pop_front());
        end
        if (mem_rd || mem_wr) begin
          if (sq.size() == 0) begin
            check("strobe_unexpected", {mem_rd, mem_wr}, 2'b00);
          end else begin
            o_s = sq.pop_front();
            check("strobe_cycle", 64'(cyc), 64'(o_s.cyc));
            check("strobe_kind", {mem_rd, mem_wr}, {~o_s.we, o_s.we});
            check("strobe_addr", mem_addr, o_s.addr);
            check("strobe_wdata", mem_wdata, o_s.wdata);
          end
        end else begin
          check("mem_idle", {mem_addr, mem_wdata}, 24'h0);
        end
        if (cpu_ack || host_ack) begin
          if (aq.size() == 0) begin
            check("ack_unexpected", {cpu_ack, host_ack}, 2'b00);
          end else begin
            o_a = aq.pop_front();
            check("ack_cycle", 64'(cyc), 64'(o_a.cyc));
            check("ack_owner", {cpu_ack, host_ack}, {~o_a.sel, o_a.sel});
            check("ack_rdata", {cpu_rdata, host_rdata},
                  o_a.sel ? {16'h0000, o_a.rdata} : {o_a.rdata, 16'h0000});
            if (log_en) ack_log.push_back(host_ack);
          end
        end else begin
          check("rdata_idle", {cpu_rdata, host_rdata}, 32'h0);
        end
        check("cpu_stall", cpu_stall, cpu_req & ~cpu_ack);
      end
    end
  end

  // Stimulus sequence
  logic exp_host;
  logic act_host;
  initial begin
    // Both requests high through reset, then continuous contention
    rst = 1'b0; cpu_pct = 100; host_pct = 100;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1; log_en = 1'b1;
    repeat (32) @(posedge clk);
    #2 log_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_host = (i == 4) || (i == 9);
      act_host = (i < ack_log.size()) ? ack_log[i] : 1'bx;
      check("starve_order", act_host, exp_host);
    end

    // Random traffic with random reset pulses at arbitrary FSM phases
    for (int r = 0; r < 12; r++) begin
      cpu_pct  = int'($urandom_range(90, 10));
      host_pct = int'($urandom_range(90, 10));
      repeat ($urandom_range(300, 100)) @(posedge clk);
      #3 rst = 1'b0;
      repeat ($urandom_range(2, 1)) @(posedge clk);
      #3 rst = 1'b1;
    end

    // Drain outstanding requests and confirm every prediction was consumed
    cpu_pct = 0; host_pct = 0;
    repeat (16) @(posedge clk);
    #2 check("drain", 64'(sq.size() + aq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 256x16 data memory between the processor controller (CPU port) and an external host/debug loader (HOST port). It sits between the requesters and the data memory and serialises accesses through a three-state FSM, with the CPU given fixed priority. A wait counter bounds host starvation. It also produces a stall signal that the controller uses to hold its current state while its access is pending.

## Interface
- `MAX_WAIT`, default 4: number of consecutive lost arbitrations after which the host is force-granted. Legal range 1..15.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: CPU access request. Held with `cpu_we`, `cpu_addr`, `cpu_wdata` stable until `cpu_ack`.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input 8: word address.
- `cpu_wdata` input 16: write data.
- `cpu_ack` output 1: one-cycle completion pulse.
- `cpu_rdata` output 16: read data, valid only while `cpu_ack`=1 for a read; otherwise 0x0000.
- `cpu_stall` output 1: `cpu_req & ~cpu_ack` (combinational).
- `host_req`, `host_we`, `host_addr[7:0]`, `host_wdata[15:0]`, `host_ack`, `host_rdata[15:0]`: same meanings as the CPU port.
- `mem_rd` output 1: memory read strobe.
- `mem_wr` output 1: memory write strobe.
- `mem_addr` output 8: memory address.
- `mem_wdata` output 16: memory write data.
- `mem_rdata` input 16: memory read data. It is registered in the memory and valid the cycle after `mem_rd`.

## Operation
- FSM states: IDLE, ACCESS, DONE. Transitions are IDLE→ACCESS (any request present), ACCESS→DONE (always), DONE→IDLE (always). Throughput is one access per 3 cycles.
- Arbitration is performed in IDLE only:
  - Host wins if `host_req` and (`~cpu_req` or `wait_cnt` ≥ `MAX_WAIT`).
  - Otherwise CPU wins if `cpu_req`.
  - With no requests, the FSM stays in IDLE.
- On the IDLE→ACCESS edge, the winner's `we`, `addr` and `wdata` are latched into internal registers, along with a `sel` bit (0 = CPU, 1 = HOST).
- In ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_rd` = ~latched `we`; `mem_wr` = latched `we`.
- In DONE:
  - The winner's `ack` = 1.
  - The winner's `rdata` = `mem_rdata` if the access was a read, else 0x0000.
  - The loser's `ack` and `rdata` = 0.
- Outside ACCESS, `mem_rd`, `mem_wr`, `mem_addr` and `mem_wdata` are all 0.
- `wait_cnt` (4-bit), updated only on an IDLE→ACCESS edge:
  - +1, saturating at 15, if `host_req`=1 and the CPU wins.
  - Cleared to 0 if the host wins.
  - Otherwise unchanged.
- A request still high in the IDLE cycle after its ack is treated as a new request; no request is ever dropped or merged.
- Requester inputs that change while the FSM is in ACCESS or DONE have no effect on the in-flight access.

## Timing
- Reset (`rst`=0, asynchronous):
  - State → IDLE, `wait_cnt` → 0, latched fields → 0.
  - All outputs 0 immediately, including `mem_wr` mid-ACCESS.
  - An in-flight access is abandoned with no ack. `cpu_stall` follows `cpu_req` during reset.
  - First arbitration happens in the first IDLE cycle after `rst` returns high.
- Latency for a request presented in IDLE cycle N:
  - Strobe in cycle N+1.
  - `ack`/`rdata` in cycle N+2.
  - Earliest next arbitration in cycle N+3.
- A request arriving while the FSM is in ACCESS or DONE waits. It is arbitrated at the next IDLE, so worst case is +2 cycles before arbitration.
- Simultaneous requests in IDLE with `wait_cnt` < `MAX_WAIT`: CPU wins and `wait_cnt` increments.
- Host worst-case wait: `MAX_WAIT`+1 arbitrations, i.e. 3·(`MAX_WAIT`+1) cycles.
- Writes commit at the end of the ACCESS cycle. A read of the same address in any later access returns the new data.

## Test plan
- Reset: drive `rst`=0 with both requests high → all `ack`/`mem_*`/`rdata` = 0, `cpu_stall`=1. Release `rst` → CPU granted, `mem_rd`=1 one cycle later.
- CPU read alone, `cpu_addr`=0x12, memory holds 0xBEEF, `cpu_req` in IDLE at cycle N → `mem_rd`=1 and `mem_addr`=0x12 at N+1; `cpu_ack`=1 and `cpu_rdata`=0xBEEF at N+2; `cpu_stall` 1 at N and N+1, 0 at N+2.
- Host write then CPU read → host write 0x5A5A to 0x34: `mem_wr`=1 at N+1, `host_ack` at N+2, `host_rdata`=0x0000. CPU read of 0x34 starting N+3 → `cpu_rdata`=0x5A5A at N+5.
- Starvation with `MAX_WAIT`=4, both requests held high continuously → grant order CPU, CPU, CPU, CPU, HOST, CPU…; `host_ack` first at the 5th DONE; `wait_cnt` back to 0 after the host grant.
- Reset mid-write: CPU write to 0x40 of 0x1111, assert `rst`=0 during ACCESS → `mem_wr` falls within the same cycle, no `cpu_ack`. After release, a host read of 0x40 returns the old contents if `mem_wr` was never sampled by the memory.
- Late arrival: `host_req` rises during a CPU access's ACCESS cycle → CPU completes undisturbed; host is granted at the next IDLE, strobe in the following cycle; `wait_cnt` unchanged at 0.
